// File: rtl/fir_decimator.sv
// Block-average decimator: sums DECIM input results, pushes the truncated mean into a FWFT FIFO.
// Latency 1 edge from the DECIM-th sample to DEC_OUT; DEC_READY low holds the head, a full FIFO drops and flags.
module fir_decimator #(
   parameter int DATA_W     = 18,
   parameter int LOG2_DECIM = 2,
   parameter int DECIM      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [DATA_W-1:0]             Y_ALL,
   input  logic                          Y_VALID,
   output logic [DATA_W-1:0]             DEC_OUT,
   output logic                          DEC_VALID,
   input  logic                          DEC_READY,
   output logic [$clog2(FIFO_DEPTH):0]   FILL,
   output logic                          OVERFLOW
);

   localparam int ACC_W  = DATA_W + LOG2_DECIM;
   localparam int CNT_W  = LOG2_DECIM;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FILL_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECIM - 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FIFO_DEPTH);

   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

   logic [ACC_W-1:0]  sum;
   logic [DATA_W-1:0] avg;
   logic              push, pop, full, wr_en;

   always_comb begin
      sum      = acc_q + {{LOG2_DECIM{1'b0}}, Y_ALL};
      avg      = sum[ACC_W-1:LOG2_DECIM];
      push     = Y_VALID && (cnt_q == CNT_LAST);
      pop      = DEC_READY && (fill_q != '0);
      full     = (fill_q == FILL_MAX);
      // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
      wr_en    = push && (!full || pop);

      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (Y_VALID) begin
         if (push) begin
            acc_d = '0;
            cnt_d = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      fill_d   = fill_q;
      if (wr_en && !pop)
         fill_d = fill_q + FILL_W'(1);
      else if (!wr_en && pop)
         fill_d = fill_q - FILL_W'(1);

      rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      ovf_d    = ovf_q || (push && full && !pop);

      // The incoming word bypasses memory when it becomes the new head.
      head_d   = head_q;
      if (wr_en && ((fill_q == '0) || (pop && fill_q == FILL_W'(1))))
         head_d = avg;
      else if (fill_d != '0)
         head_d = mem_q[rd_ptr_d];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         fill_q   <= '0;
         head_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         head_q   <= head_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en)
         mem_q[wr_ptr_q] <= avg;
   end

   assign DEC_OUT   = head_q;
   assign DEC_VALID = (fill_q != '0);
   assign FILL      = fill_q;
   assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator with hand-computed expected averages.
module tb_fir_decimator;

   logic        CLK = 1'b0;
   logic        RST;
   logic [17:0] Y_ALL;
   logic        Y_VALID;
   logic [17:0] DEC_OUT;
   logic        DEC_VALID;
   logic        DEC_READY;
   logic [2:0]  FILL;
   logic        OVERFLOW;

   int n_checks = 0;
   int n_fails  = 0;

   fir_decimator dut (
      .CLK(CLK), .RST(RST), .Y_ALL(Y_ALL), .Y_VALID(Y_VALID),
      .DEC_OUT(DEC_OUT), .DEC_VALID(DEC_VALID), .DEC_READY(DEC_READY),
      .FILL(FILL), .OVERFLOW(OVERFLOW)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic sample(input logic [17:0] v);
      Y_ALL   = v;
      Y_VALID = 1'b1;
      tick();
      Y_VALID = 1'b0;
   endtask

   task automatic block(input logic [17:0] v);
      for (int i = 0; i < 4; i++) sample(v);
   endtask

   task automatic idle(input int n);
      Y_VALID = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      RST = 1'b1; Y_ALL = '0; Y_VALID = 1'b0; DEC_READY = 1'b1;
      #2;
      check("rst_dec_out",   32'(DEC_OUT),   0);
      check("rst_dec_valid", 32'(DEC_VALID), 0);
      check("rst_fill",      32'(FILL),      0);
      check("rst_overflow",  32'(OVERFLOW),  0);
      tick();
      RST = 1'b0;
      tick();

      // Basic block average
      sample(10); sample(20); sample(30);
      check("t1_not_yet", 32'(DEC_VALID), 0);
      sample(40);
      check("t1_valid", 32'(DEC_VALID), 1);
      check("t1_out",   32'(DEC_OUT),   25);
      check("t1_fill",  32'(FILL),      1);
      idle(1);
      check("t1_valid_drop", 32'(DEC_VALID), 0);
      check("t1_fill_zero",  32'(FILL),      0);

      // Truncation and max value
      sample(1); sample(1); sample(1); sample(2);
      check("t2_trunc", 32'(DEC_OUT), 1);
      check("t2_trunc_valid", 32'(DEC_VALID), 1);
      block(18'd262143);
      check("t2_max", 32'(DEC_OUT), 262143);
      check("t2_max_valid", 32'(DEC_VALID), 1);
      check("t2_ovf", 32'(OVERFLOW), 0);
      idle(1);

      // Gapped input
      sample(4); idle(3); sample(8); sample(12); idle(5);
      check("t3_not_yet", 32'(DEC_VALID), 0);
      sample(16);
      check("t3_out",   32'(DEC_OUT),   10);
      check("t3_valid", 32'(DEC_VALID), 1);
      idle(1);
      check("t3_empty", 32'(FILL), 0);

      // Backpressure and overflow
      DEC_READY = 1'b0;
      for (int k = 1; k <= 5; k++) block(18'(k));
      check("t4_fill", 32'(FILL),     4);
      check("t4_ovf",  32'(OVERFLOW), 1);
      check("t4_head", 32'(DEC_OUT),  1);
      DEC_READY = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         tick();
         check("t4_drain_out",  32'(DEC_OUT), 32'(k));
         check("t4_drain_fill", 32'(FILL),    32'(5 - k));
      end
      tick();
      check("t4_drained", 32'(DEC_VALID), 0);
      check("t4_ovf_sticky", 32'(OVERFLOW), 1);

      RST = 1'b1; #2;
      check("t4_rst_ovf", 32'(OVERFLOW), 0);
      RST = 1'b0;
      tick();

      // Full FIFO with simultaneous push and pop
      DEC_READY = 1'b0;
      for (int k = 1; k <= 4; k++) block(18'(k));
      check("t5_full", 32'(FILL), 4);
      sample(9); sample(9); sample(9);
      DEC_READY = 1'b1;
      sample(9);
      check("t5_fill",  32'(FILL),     4);
      check("t5_ovf",   32'(OVERFLOW), 0);
      check("t5_head",  32'(DEC_OUT),  2);
      tick(); check("t5_d3", 32'(DEC_OUT), 3); check("t5_f3", 32'(FILL), 3);
      tick(); check("t5_d4", 32'(DEC_OUT), 4); check("t5_f2", 32'(FILL), 2);
      tick(); check("t5_d9", 32'(DEC_OUT), 9); check("t5_f1", 32'(FILL), 1);
      tick(); check("t5_empty", 32'(DEC_VALID), 0);
      check("t5_ovf_end", 32'(OVERFLOW), 0);

      // Asynchronous reset mid-block
      DEC_READY = 1'b0;
      block(7);
      check("t6_pre_out", 32'(DEC_OUT), 7);
      sample(100); sample(100);
      #2; RST = 1'b1; #1;
      check("t6_rst_out",   32'(DEC_OUT),   0);
      check("t6_rst_valid", 32'(DEC_VALID), 0);
      check("t6_rst_fill",  32'(FILL),      0);
      RST = 1'b0;
      DEC_READY = 1'b1;
      tick();
      sample(8); sample(8);
      check("t6_no_partial", 32'(DEC_VALID), 0);
      sample(8);
      check("t6_no_partial3", 32'(DEC_VALID), 0);
      sample(8);
      check("t6_out",   32'(DEC_OUT),   8);
      check("t6_valid", 32'(DEC_VALID), 1);
      idle(1);
      check("t6_single", 32'(DEC_VALID), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream stage of the 3-tap FIR filter. Consumes the filter's 18-bit result stream, one word per valid strobe.
- Averages every DECIM consecutive results into one output word (block-average decimation).
- Queues averaged words in a small FIFO and delivers them to the next consumer through a valid/ready handshake.
- Flags any averaged word lost because the FIFO was full.

Parameters:
- DATA_W, 18, width of input results and output averages.
- LOG2_DECIM, 2, log2 of decimation factor.
- DECIM, 4, decimation factor; must equal 2**LOG2_DECIM.
- FIFO_DEPTH, 4, output FIFO depth in words; power of two, at least 2.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- Y_ALL  in  DATA_W  FIR result word, unsigned.
- Y_VALID  in  1  Y_ALL is sampled on a rising edge where this is 1.
- DEC_OUT  out  DATA_W  averaged word at the FIFO head.
- DEC_VALID  out  1  DEC_OUT holds a valid word.
- DEC_READY  in  1  consumer accepts DEC_OUT on a rising edge where DEC_VALID and DEC_READY are both 1.
- FILL  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- OVERFLOW  out  1  sticky flag: at least one averaged word was dropped.

Behaviour:
- Reset (asynchronous, RST=1):
  - Accumulator ACC (DATA_W+LOG2_DECIM bits) = 0; sample counter CNT = 0.
  - FIFO emptied.
  - Outputs: DEC_OUT=0, DEC_VALID=0, FILL=0, OVERFLOW=0.
  - Effective immediately, with no clock edge needed. Any partial block is discarded.
- Accumulator, on each edge with Y_VALID=1:
  - If CNT < DECIM-1: ACC <= ACC + Y_ALL; CNT <= CNT+1.
  - If CNT = DECIM-1: SUM = ACC + Y_ALL; AVG = SUM >> LOG2_DECIM (truncation, no rounding); push AVG; ACC <= 0; CNT <= 0.
  - ACC width guarantees no overflow: the maximum SUM is DECIM*(2**DATA_W-1).
- When Y_VALID=0, ACC and CNT hold. Gaps between valid samples of any length are allowed.
- FIFO is first-word-fall-through with a registered head:
  - DEC_VALID = (FILL != 0). DEC_OUT = oldest stored word.
  - A word pushed into an empty FIFO appears on DEC_OUT with DEC_VALID=1 immediately after the pushing edge (latency: 1 edge from the DECIM-th sample).
- Pop: on an edge where DEC_VALID and DEC_READY are both 1, the head is removed and the next word (if any) is presented after that edge.
- DEC_OUT holds its value while DEC_VALID=1 and DEC_READY=0.
- When FIFO is empty, DEC_OUT holds its last value. Consumers must ignore it while DEC_VALID=0.
- DEC_READY with DEC_VALID=0 has no effect.
- Push and pop on the same edge:
  - Both are performed; FILL is unchanged.
  - Also applies when the FIFO is full: the pop frees the slot and the push is accepted with no drop.
- Push with FIFO full and no pop on that edge: AVG is discarded, FIFO is unchanged, OVERFLOW <= 1.
- OVERFLOW stays 1 until reset.
- Pointer wrap-around: read and write pointers wrap modulo FIFO_DEPTH. Full vs empty is distinguished by FILL, not by pointer equality.
- Output order is strictly arrival order. There is no reordering or duplication.

Test Plan:
- DECIM=4, DEC_READY=1; feed 10,20,30,40 on consecutive valid edges -> one word DEC_OUT=25, DEC_VALID high for exactly 1 cycle after the 4th edge; FILL returns to 0.
- Truncation and max value: feed 1,1,1,2 -> 1. Then feed 262143 four times -> 262143. OVERFLOW=0 throughout.
- Gapped input: samples 4,8,12,16 separated by 0-5 idle cycles with Y_VALID=0 -> single output 10, produced only after the 4th valid sample.
- Backpressure: DEC_READY=0, feed 5 blocks averaging 1..5 -> FILL=4, OVERFLOW=1. Then DEC_READY=1 -> drains 1,2,3,4 in order; block 5 is never output.
- Full with simultaneous push/pop: FIFO holds 1,2,3,4; assert DEC_READY on the same edge a block averaging 9 completes -> FILL stays 4, OVERFLOW stays 0, drain order 2,3,4,9 follows the popped 1.
- Asynchronous reset mid-block: feed 100,100, pulse RST between edges -> outputs clear without a clock edge. Then feed 8,8,8,8 -> single output 8, confirming the partial block was discarded.
